// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer between a FIR output stream and a fixed-latency FFT.
// Counts samples into frames, flags each frame result after PIPE_LAT cycles, runs TOTAL_FRAMES frames.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begins a run when sampled high in IDLE
//   abort      cancels a run in progress; wins over start in IDLE
//   fir_valid  FIR sample present this cycle
//   sample_en  combinational: datapath shifts in the FIR sample this cycle
//   sample_cnt position of the next sample within the current frame
//   fft_valid  one-cycle pulse: FFT outputs hold a complete frame
//   frame_idx  index of the frame flagged by fft_valid; holds otherwise
//   busy       high in RUN and FLUSH
//   done       one-cycle pulse at end of a completed run
module fft_frame_ctrl #(
  parameter int FRAME_LEN    = 16,
  parameter int PIPE_LAT     = 5,
  parameter int TOTAL_FRAMES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         fir_valid,
  output logic                         sample_en,
  output logic [$clog2(FRAME_LEN)-1:0] sample_cnt,
  output logic                         fft_valid,
  output logic [6:0]                   frame_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [6:0] FRM_LAST = 7'(TOTAL_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t              state;
  logic [6:0]          in_frames;
  logic [6:0]          out_frames;
  logic [PIPE_LAT-1:0] dly;
  logic [PIPE_LAT:0]   dly_n;
  logic                frame_end;

  assign sample_en = fir_valid && (state == RUN) && !abort;
  assign frame_end = sample_en && (sample_cnt == CNT_LAST);

  // One flag per frame in flight; overlapping frames occupy separate bits.
  assign dly_n     = {dly, frame_end};
  assign fft_valid = dly[PIPE_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      in_frames  <= '0;
      out_frames <= '0;
      dly        <= '0;
      frame_idx  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      dly  <= dly_n[PIPE_LAT-1:0];
      // Power-of-two length: natural wrap returns to 0 at frame end.
      if (sample_en)
        sample_cnt <= sample_cnt + CW'(1);
      if (frame_end)
        in_frames <= in_frames + 7'd1;
      if (fft_valid)
        out_frames <= out_frames + 7'd1;
      // Load the index as the flag reaches the output so it is
      // stable for the whole pulse and held afterwards.
      if (dly_n[PIPE_LAT-1] && !abort)
        frame_idx <= out_frames + 7'(fft_valid);

      if (busy && abort) begin
        state      <= IDLE;
        busy       <= 1'b0;
        sample_cnt <= '0;
        in_frames  <= '0;
        out_frames <= '0;
        dly        <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              state      <= RUN;
              busy       <= 1'b1;
              sample_cnt <= '0;
              in_frames  <= '0;
              out_frames <= '0;
              dly        <= '0;
            end
          end
          RUN: begin
            if (frame_end && (in_frames == FRM_LAST))
              state <= FLUSH;
          end
          FLUSH: begin
            if (fft_valid && (out_frames == FRM_LAST)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: scoreboard bench for fft_frame_ctrl.
// Three configurations share one stimulus stream; expected pulses are queued at frame end.
module tb_fft_frame_ctrl;

  localparam int FL [3] = '{16, 4, 2};
  localparam int PL [3] = '{5, 8, 1};
  localparam int TF [3] = '{64, 3, 1};

  typedef struct {
    int cyc;
    int idx;
  } pls_t;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic fir_valid;

  logic       se [3];
  logic       fv [3];
  logic       bz [3];
  logic       dn [3];
  logic [6:0] fi [3];
  int         sc [3];

  logic [3:0] cnt_a;
  logic [1:0] cnt_b;
  logic       cnt_c;

  assign sc[0] = 32'(cnt_a);
  assign sc[1] = 32'(cnt_b);
  assign sc[2] = 32'(cnt_c);

  fft_frame_ctrl #(
    .FRAME_LEN(FL[0]), .PIPE_LAT(PL[0]), .TOTAL_FRAMES(TF[0])
  ) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fir_valid(fir_valid), .sample_en(se[0]), .sample_cnt(cnt_a),
    .fft_valid(fv[0]), .frame_idx(fi[0]), .busy(bz[0]), .done(dn[0])
  );

  fft_frame_ctrl #(
    .FRAME_LEN(FL[1]), .PIPE_LAT(PL[1]), .TOTAL_FRAMES(TF[1])
  ) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fir_valid(fir_valid), .sample_en(se[1]), .sample_cnt(cnt_b),
    .fft_valid(fv[1]), .frame_idx(fi[1]), .busy(bz[1]), .done(dn[1])
  );

  fft_frame_ctrl #(
    .FRAME_LEN(FL[2]), .PIPE_LAT(PL[2]), .TOTAL_FRAMES(TF[2])
  ) u_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fir_valid(fir_valid), .sample_en(se[2]), .sample_cnt(cnt_c),
    .fft_valid(fv[2]), .frame_idx(fi[2]), .busy(bz[2]), .done(dn[2])
  );

  always #5 clk = ~clk;

  int   nvec;
  int   nerr;
  int   n;
  int   mst  [3];
  int   acc  [3];
  int   lastc[3];
  int   lidx [3];
  int   fec  [3];
  pls_t sbq  [3][$];

  task automatic chk(input string tag, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic mdl_reset(input int i);
    mst[i]   = 0;
    acc[i]   = 0;
    lastc[i] = -1;
    lidx[i]  = 0;
    fec[i]   = -100;
    sbq[i].delete();
  endtask

  task automatic compare(input int i, input logic a, input logic v);
    int ev;
    int ei;
    ev = 0;
    ei = lidx[i];
    if (sbq[i].size() > 0 && sbq[i][0].cyc == n) begin
      ev = 1;
      ei = sbq[i][0].idx;
      lidx[i] = ei;
      void'(sbq[i].pop_front());
    end
    chk($sformatf("u%0d.fft_valid@%0d", i, n), int'(fv[i]), ev);
    chk($sformatf("u%0d.frame_idx@%0d", i, n), int'(fi[i]), ei);
    chk($sformatf("u%0d.sample_en@%0d", i, n), int'(se[i]),
        int'(v && mst[i] == 1 && !a));
    chk($sformatf("u%0d.sample_cnt@%0d", i, n), sc[i], acc[i] % FL[i]);
    chk($sformatf("u%0d.busy@%0d", i, n), int'(bz[i]),
        int'(mst[i] == 1 || mst[i] == 2));
    chk($sformatf("u%0d.done@%0d", i, n), int'(dn[i]), int'(mst[i] == 3));
  endtask

  task automatic advance(input int i, input logic s, a, v, r);
    pls_t e;
    if (r) begin
      mdl_reset(i);
      return;
    end
    case (mst[i])
      0: if (s && !a) begin
        mst[i] = 1;
        acc[i] = 0;
      end
      1: if (a) begin
        mst[i] = 0;
        acc[i] = 0;
        sbq[i].delete();
      end else if (v) begin
        if (acc[i] % FL[i] == FL[i] - 1) begin
          e.cyc = n + PL[i];
          e.idx = acc[i] / FL[i];
          sbq[i].push_back(e);
          fec[i] = n;
          if (e.idx == TF[i] - 1) begin
            lastc[i] = e.cyc;
            mst[i] = 2;
          end
        end
        acc[i]++;
      end
      2: if (a) begin
        mst[i] = 0;
        acc[i] = 0;
        sbq[i].delete();
      end else if (n == lastc[i]) begin
        mst[i] = 3;
      end
      default: mst[i] = 0;
    endcase
  endtask

  task automatic tick(input logic s, a, v, r);
    @(posedge clk);
    #1;
    start     = s;
    abort     = a;
    fir_valid = v;
    rst       = r;
    n++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      compare(i, a, v);
      advance(i, s, a, v, r);
    end
  endtask

  int found;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fir_valid = 1'b0;
    nvec = 0;
    nerr = 0;
    n = 0;
    for (int i = 0; i < 3; i++)
      mdl_reset(i);

    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);

    // continuous stream, stray starts mid-run
    tick(1, 0, 0, 0);
    for (int k = 0; k < 1050; k++)
      tick(k == 20 || k == 300, 0, 1, 0);
    for (int k = 0; k < 10; k++)
      tick(0, 0, 0, 0);

    // alternating valid, abort 3 cycles after a frame end
    tick(1, 0, 0, 0);
    found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      if (acc[0] >= 3 * FL[0] && n + 1 == fec[0] + 3) begin
        tick(0, 1, 1, 0);
        found = 1;
      end else begin
        tick(0, 0, k[0] == 1'b0, 0);
      end
    end
    chk("abort_point", found, 1);
    for (int k = 0; k < 12; k++)
      tick(0, 0, 0, 0);

    // clean rerun after abort
    tick(1, 0, 0, 0);
    for (int k = 0; k < 1040; k++)
      tick(0, 0, 1, 0);
    for (int k = 0; k < 5; k++)
      tick(0, 0, 0, 0);

    // reset during FLUSH
    tick(1, 0, 0, 0);
    found = 0;
    for (int k = 0; k < 1100 && found == 0; k++) begin
      tick(0, 0, 1, 0);
      if (mst[0] == 2)
        found = 1;
    end
    chk("flush_reached", found, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 1);
    for (int k = 0; k < 15; k++)
      tick(0, 0, 1, 0);

    // start and abort together in IDLE
    tick(1, 1, 1, 0);
    for (int k = 0; k < 5; k++)
      tick(0, 0, 1, 0);

    for (int i = 0; i < 3; i++)
      chk($sformatf("u%0d.pending", i), sbq[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, samples per FFT frame (power of two, 2..64).
REQ-002 SHALL have parameter PIPE_LAT, default 5, cycles from accept of a frame's last sample to its FFT result being valid (1..15).
REQ-003 SHALL have parameter TOTAL_FRAMES, default 64, frames per run (1..127).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1, begins a run when sampled high in IDLE.
REQ-007 SHALL have port abort, input, 1, cancels a run in progress.
REQ-008 SHALL have port fir_valid, input, 1, FIR output sample present this cycle.
REQ-009 SHALL have port sample_en, output, 1, combinational: datapath shifts in fir_d this cycle.
REQ-010 SHALL have port sample_cnt, output, log2(FRAME_LEN), position of the next sample within the current frame.
REQ-011 SHALL have port fft_valid, output, 1, one-cycle pulse: FFT outputs hold a complete frame result.
REQ-012 SHALL have port frame_idx, output, 7, index of the frame flagged by fft_valid, 0-based.
REQ-013 SHALL have port busy, output, 1, high in RUN and FLUSH.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at end of run.

Function
REQ-015 SHALL implement states IDLE, RUN, FLUSH, DONE, registered.
REQ-016 IDLE: start=1 -> RUN; sample_cnt, in_frames, out_frames and delay line cleared on that edge.
REQ-017 sample_en SHALL equal fir_valid AND state==RUN AND abort==0; zero in every other state.
REQ-018 Each sample_en cycle SHALL increment sample_cnt modulo FRAME_LEN; no increment when fir_valid is low (gaps are stalls, not frame resets).
REQ-019 A sample_en cycle with sample_cnt==FRAME_LEN-1 SHALL be a frame end: in_frames increments and a flag enters a PIPE_LAT-deep delay line.
REQ-020 fft_valid SHALL be asserted exactly PIPE_LAT cycles after each frame-end cycle, independent of later fir_valid activity; back-to-back frame ends (gap of FRAME_LEN cycles or fewer) SHALL each produce their own pulse.
REQ-021 frame_idx SHALL equal out_frames during an fft_valid pulse; out_frames increments after each pulse; frame_idx holds its last value otherwise.
REQ-022 RUN: the frame end that brings in_frames to TOTAL_FRAMES SHALL move state to FLUSH on the next edge; further fir_valid is ignored.
REQ-023 FLUSH: when the final fft_valid pulse (out_frames reaching TOTAL_FRAMES) has been emitted -> DONE.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 start outside IDLE SHALL be ignored; start and abort both high in IDLE: abort wins, stay IDLE.
REQ-026 abort=1 in RUN or FLUSH SHALL return to IDLE next edge, clear delay line and counters, suppress all pending fft_valid, not assert done.
REQ-027 Counters SHALL never wrap past TOTAL_FRAMES; FRAME_LEN sample counter wraps to 0 at frame end.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, sample_cnt=0, in/out frame counters=0, delay line=0, frame_idx=0; fft_valid, done, busy, sample_en low; rst overrides start and abort.
REQ-029 rst asserted mid-run SHALL discard all in-flight frames with no fft_valid or done afterwards.

Verification
REQ-030 Defaults, start then fir_valid continuous 1024 cycles -> 64 fft_valid pulses, first 5 cycles after 16th accept, spaced 16, frame_idx 0..63, done one cycle after the 64th pulse, sample_en low after 1024th sample.
REQ-031 fir_valid toggling 1/0 -> frame end every 32 cycles, fft_valid still exactly 5 cycles after each frame end, sample_cnt frozen in low cycles.
REQ-032 FRAME_LEN=4, PIPE_LAT=8, continuous valid -> overlapping frames in the delay line, every pulse emitted, none merged or lost.
REQ-033 abort 3 cycles after a frame end -> pending pulse for that frame never appears, no done, IDLE next cycle; next start runs cleanly from frame_idx 0.
REQ-034 rst during FLUSH -> all outputs 0 next cycle, no further pulses; start during RUN -> no effect on counters.
REQ-035 TOTAL_FRAMES=1 -> single fft_valid with frame_idx=0, then done, then IDLE with busy=0.
